// File: rtl/ahb_sram_pkg.sv
// Shared AHB-lite encodings, error-FSM states and byte-lane helpers for the
// RAM_3Kx32 responder.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_OKAY,
        ST_ERR1,
        ST_ERR2
    } err_state_t;

    function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: return 4'b0001 << addr;
            HSIZE_HALF: return addr[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: return 1'b1;
            HSIZE_HALF: return !addr[0];
            HSIZE_WORD: return addr == 2'b00;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_wbuf.sv
// Single-entry posted-write buffer with per-lane read forwarding.
module ahb_sram_wbuf #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          drain,
    input  logic [AW-1:0] load_addr,
    input  logic [3:0]    load_strb,
    input  logic [31:0]   load_data,
    input  logic [AW-1:0] fwd_addr,
    input  logic [31:0]   fwd_rdata,
    output logic          valid,
    output logic [AW-1:0] addr,
    output logic [3:0]    strb,
    output logic [31:0]   data,
    output logic [31:0]   fwd_data
);

    // A load in the same cycle as a drain re-fills the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            strb  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            strb  <= load_strb;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    logic hit;
    assign hit = valid && (addr == fwd_addr);

    always_comb begin
        fwd_data = fwd_rdata;
        for (int i = 0; i < 4; i++) begin
            if (hit && strb[i])
                fwd_data[8*i +: 8] = data[8*i +: 8];
        end
    end

endmodule

// File: rtl/ahb_sram_ctrl.sv
// Zero-wait AHB-lite responder for the RAM_3Kx32 macro: address decode,
// two-cycle ERROR sequencing and macro port muxing between reads and drains.
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int AW    = 12,
    parameter int DEPTH = 3072
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic          SRAMCS0,
    output logic [3:0]    SRAMWEN,
    output logic [AW-1:0] SRAMADDR,
    output logic [31:0]   SRAMWDATA
);

    err_state_t    state;
    logic [AW-1:0] word_addr;
    logic          accept, legal, rd_acc, wr_acc, err_acc;
    logic          rd_pend, wr_pend;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [3:0]    wr_strb;
    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [3:0]    buf_strb;
    logic [31:0]   buf_data, fwd_data;

    logic unused_bits;
    assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

    assign word_addr = HADDR[AW+1:2];
    assign accept    = HSEL && HTRANS[1] && HREADY && !HRESET;
    assign legal     = (HSIZE <= HSIZE_WORD) && is_aligned(HSIZE, HADDR[1:0])
                       && (int'(word_addr) < DEPTH);
    assign rd_acc    = accept && legal && !HWRITE;
    assign wr_acc    = accept && legal && HWRITE;
    assign err_acc   = accept && !legal;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= ST_OKAY;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            rd_pend   <= 1'b0;
            rd_addr   <= '0;
            wr_pend   <= 1'b0;
            wr_addr   <= '0;
            wr_strb   <= '0;
        end else begin
            rd_pend <= rd_acc;
            wr_pend <= wr_acc;
            if (rd_acc)
                rd_addr <= word_addr;
            if (wr_acc) begin
                wr_addr <= word_addr;
                wr_strb <= byte_strobe(HSIZE, HADDR[1:0]);
            end
            case (state)
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                default: begin
                    // ERR2 is a completing cycle, so a new transfer may start here.
                    if (err_acc) begin
                        state     <= ST_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= HRESP_ERROR;
                    end else begin
                        state     <= ST_OKAY;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    ahb_sram_wbuf #(.AW(AW)) u_wbuf (
        .clk       (HCLK),
        .rst       (HRESET),
        .load      (wr_pend),
        .drain     (buf_valid && !rd_acc),
        .load_addr (wr_addr),
        .load_strb (wr_strb),
        .load_data (HWDATA),
        .fwd_addr  (rd_addr),
        .fwd_rdata (SRAMRDATA),
        .valid     (buf_valid),
        .addr      (buf_addr),
        .strb      (buf_strb),
        .data      (buf_data),
        .fwd_data  (fwd_data)
    );

    // Reads own the macro; the buffer drains in any other cycle.
    always_comb begin
        SRAMCS0   = 1'b0;
        SRAMWEN   = 4'b0000;
        SRAMADDR  = '0;
        SRAMWDATA = buf_data;
        if (rd_acc) begin
            SRAMCS0  = 1'b1;
            SRAMADDR = word_addr;
        end else if (buf_valid) begin
            SRAMCS0  = 1'b1;
            SRAMWEN  = buf_strb;
            SRAMADDR = buf_addr;
        end
    end

    assign HRDATA = rd_pend ? fwd_data : 32'h0;

endmodule
